// File: rtl/rdout_seq.sv
// rdout_seq: readout sequencer between the trigger/block FIFO and the ADC readout path.
// Pops one SCA-block descriptor at a time and frames it as header, one word per
// selected sample position, and trailer, then pops the FIFO(s) and waits a holdoff gap.
// Optional feature macro: RDSEQ_CHKSUM_EN appends an XOR checksum word after each trailer.
// TMR=1 keeps three copies of the state, holdoff and word-count registers behind a vote.
module rdout_seq #(
  parameter int TMR     = 0,
  parameter int HOLDOFF = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        TEMPTY,
  input  logic [3:0]  BLKOUT,
  input  logic [7:0]  L1POUT,
  input  logic [7:0]  NL1ABLK,
  input  logic        SCND_BLK,
  input  logic [5:0]  L1ANUM,
  input  logic        DOUT_RDY,
  output logic [15:0] DOUT,
  output logic        DOUT_VALID,
  output logic        TRGDONE,
  output logic        POPL1AN,
  output logic        BUSY
);

`ifdef RDSEQ_CHKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HDR  = 3'd2,
    ST_SAMP = 3'd3,
    ST_TRL  = 3'd4,
    ST_CHK  = 3'd5,
    ST_POP  = 3'd6,
    ST_GAP  = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HDR  = 3'd2,
    ST_SAMP = 3'd3,
    ST_TRL  = 3'd4,
    ST_POP  = 3'd5,
    ST_GAP  = 3'd6
  } state_t;
`endif

  localparam logic [2:0] HOLD_INIT = 3'(HOLDOFF);

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  hold_q;
  logic [2:0]  hold_d;
  logic [7:0]  wcnt_q;
  logic [7:0]  wcnt_d;

  logic [3:0]  blk_q;
  logic [7:0]  mask_q;
  logic [7:0]  nl1a_q;
  logic [5:0]  l1a_q;
  logic        end_evt_q;

  logic [2:0]  cur_idx;
  logic [7:0]  mask_next;
  logic        accept;

`ifdef RDSEQ_CHKSUM_EN
  logic [15:0] chk_q;
  logic [15:0] chk_d;
`endif

  assign accept    = DOUT_VALID & DOUT_RDY;
  assign mask_next = mask_q & (mask_q - 8'd1);
  assign BUSY      = (state_q != ST_IDLE);

  generate
    if (TMR != 0) begin : g_tmr
      logic [2:0] state_r [3];
      logic [2:0] hold_r  [3];
      logic [7:0] wcnt_r  [3];

      // Three identical copies of the control registers, all fed from the same next values
      always_ff @(posedge CLK) begin
        for (int k = 0; k < 3; k++) begin
          if (RST) begin
            state_r[k] <= ST_IDLE;
            hold_r[k]  <= 3'd0;
            wcnt_r[k]  <= 8'd0;
          end else begin
            state_r[k] <= state_d;
            hold_r[k]  <= hold_d;
            wcnt_r[k]  <= wcnt_d;
          end
        end
      end

      assign state_q = state_t'((state_r[0] & state_r[1]) | (state_r[0] & state_r[2]) |
                                (state_r[1] & state_r[2]));
      assign hold_q  = (hold_r[0] & hold_r[1]) | (hold_r[0] & hold_r[2]) | (hold_r[1] & hold_r[2]);
      assign wcnt_q  = (wcnt_r[0] & wcnt_r[1]) | (wcnt_r[0] & wcnt_r[2]) | (wcnt_r[1] & wcnt_r[2]);
    end else begin : g_single
      // Single copy of the control registers
      always_ff @(posedge CLK) begin
        if (RST) begin
          state_q <= ST_IDLE;
          hold_q  <= 3'd0;
          wcnt_q  <= 8'd0;
        end else begin
          state_q <= state_d;
          hold_q  <= hold_d;
          wcnt_q  <= wcnt_d;
        end
      end
    end
  endgenerate

  // Capture the head descriptor on LOAD and retire one mask bit per accepted sample word
  always_ff @(posedge CLK) begin
    if (RST) begin
      blk_q     <= 4'd0;
      mask_q    <= 8'd0;
      nl1a_q    <= 8'd0;
      l1a_q     <= 6'd0;
      end_evt_q <= 1'b0;
    end else if (state_q == ST_LOAD) begin
      blk_q     <= BLKOUT;
      mask_q    <= L1POUT;
      nl1a_q    <= NL1ABLK;
      l1a_q     <= L1ANUM;
      end_evt_q <= SCND_BLK | ~L1POUT[7];
    end else if ((state_q == ST_SAMP) && accept) begin
      mask_q    <= mask_next;
    end
  end

`ifdef RDSEQ_CHKSUM_EN
  // Running XOR of the words of the current event
  always_ff @(posedge CLK) begin
    if (RST) begin
      chk_q <= 16'h0000;
    end else begin
      chk_q <= chk_d;
    end
  end
`endif

  // Lowest remaining mask bit is the sample position currently being emitted
  always_comb begin
    cur_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i]) begin
        cur_idx = 3'(i);
      end
    end
  end

  // Next-state, holdoff counter, event word count and checksum updates
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    wcnt_d  = wcnt_q;
`ifdef RDSEQ_CHKSUM_EN
    chk_d   = chk_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!TEMPTY && (hold_q == 3'd0)) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!SCND_BLK) begin
          state_d = ST_HDR;
        end else if (L1POUT != 8'd0) begin
          state_d = ST_SAMP;
        end else begin
          state_d = ST_TRL;
        end
      end
      ST_HDR: begin
        if (accept) begin
          wcnt_d = 8'd0;
`ifdef RDSEQ_CHKSUM_EN
          chk_d  = DOUT;
`endif
          if (mask_q != 8'd0) begin
            state_d = ST_SAMP;
          end else if (end_evt_q) begin
            state_d = ST_TRL;
          end else begin
            state_d = ST_POP;
          end
        end
      end
      ST_SAMP: begin
        if (accept) begin
          wcnt_d = wcnt_q + 8'd1;
`ifdef RDSEQ_CHKSUM_EN
          chk_d  = chk_q ^ DOUT;
`endif
          if (mask_next == 8'd0) begin
            state_d = end_evt_q ? ST_TRL : ST_POP;
          end
        end
      end
      ST_TRL: begin
        if (accept) begin
`ifdef RDSEQ_CHKSUM_EN
          chk_d   = chk_q ^ DOUT;
          state_d = ST_CHK;
`else
          state_d = ST_POP;
`endif
        end
      end
`ifdef RDSEQ_CHKSUM_EN
      ST_CHK: begin
        if (accept) begin
          state_d = ST_POP;
        end
      end
`endif
      ST_POP: begin
        hold_d  = HOLD_INIT;
        state_d = ST_GAP;
        if (end_evt_q) begin
          wcnt_d = 8'd0;
`ifdef RDSEQ_CHKSUM_EN
          chk_d  = 16'h0000;
`endif
        end
      end
      ST_GAP: begin
        if (hold_q != 3'd0) begin
          hold_d = hold_q - 3'd1;
        end
        if (hold_q <= 3'd1) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = 3'd0;
      end
    endcase
  end

  // Output words and FIFO pop pulses decoded from the current state
  always_comb begin
    DOUT       = 16'h0000;
    DOUT_VALID = 1'b0;
    TRGDONE    = 1'b0;
    POPL1AN    = 1'b0;
    case (state_q)
      ST_HDR: begin
        DOUT_VALID = 1'b1;
        DOUT       = {2'b10, l1a_q, nl1a_q};
      end
      ST_SAMP: begin
        DOUT_VALID = 1'b1;
        DOUT       = {2'b01, 6'b000000, blk_q, 1'b0, cur_idx};
      end
      ST_TRL: begin
        DOUT_VALID = 1'b1;
        DOUT       = {2'b11, l1a_q, wcnt_q};
      end
`ifdef RDSEQ_CHKSUM_EN
      ST_CHK: begin
        DOUT_VALID = 1'b1;
        DOUT       = chk_q;
      end
`endif
      ST_POP: begin
        TRGDONE = 1'b1;
        POPL1AN = end_evt_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_rdout_seq.sv
// tb_rdout_seq: self-checking bench for rdout_seq with a transaction-level model of the
// block FIFO, the L1A-number FIFO and the expected framed word stream.
module tb_rdout_seq;

  localparam int HOLD = 2;

  typedef struct packed {
    logic [3:0] b;
    logic [7:0] m;
    logic [7:0] n;
    logic       s;
  } ent_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        TEMPTY;
  logic [3:0]  BLKOUT;
  logic [7:0]  L1POUT;
  logic [7:0]  NL1ABLK;
  logic        SCND_BLK;
  logic [5:0]  L1ANUM;
  logic        DOUT_RDY;
  logic [15:0] DOUT;
  logic        DOUT_VALID;
  logic        TRGDONE;
  logic        POPL1AN;
  logic        BUSY;

  rdout_seq #(.TMR(0), .HOLDOFF(HOLD)) dut (
    .CLK(CLK), .RST(RST), .TEMPTY(TEMPTY), .BLKOUT(BLKOUT), .L1POUT(L1POUT),
    .NL1ABLK(NL1ABLK), .SCND_BLK(SCND_BLK), .L1ANUM(L1ANUM), .DOUT_RDY(DOUT_RDY),
    .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .TRGDONE(TRGDONE), .POPL1AN(POPL1AN), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  ent_t        blk_fifo[$];
  logic [5:0]  l1a_all[$];
  int          l1a_head;
  int          mdl_ptr;
  logic [7:0]  mdl_wcnt;
  logic [15:0] mdl_chk;
  logic [15:0] exp_words[$];
  logic        exp_pops[$];
  logic [15:0] acc_log[$];
  logic        pop_log[$];
  logic [15:0] lit[$];
  logic        plit[$];

  int          tests;
  int          fails;
  int          cyc;
  logic        mon_en;
  int          rdy_mode;
  int          low_from;
  logic        prev_hold;
  logic [15:0] prev_dout;
  int          hold_checks;
  logic        pop_seen;
  int          since_pop;
  int          idle_cnt;
  int          last_gap;
  int          last_idle;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic present();
    TEMPTY = (blk_fifo.size() == 0);
    if (!TEMPTY) begin
      BLKOUT   = blk_fifo[0].b;
      L1POUT   = blk_fifo[0].m;
      NL1ABLK  = blk_fifo[0].n;
      SCND_BLK = blk_fifo[0].s;
    end else begin
      BLKOUT   = 4'd0;
      L1POUT   = 8'd0;
      NL1ABLK  = 8'd0;
      SCND_BLK = 1'b0;
    end
    L1ANUM = (l1a_head < l1a_all.size()) ? l1a_all[l1a_head] : 6'd0;
  endtask

  // Framing rules for one block, appended to the expected word and pop streams
  task automatic applyStimulus(input logic [3:0] b, input logic [7:0] m, input logic [7:0] n,
                               input logic s);
    ent_t        e;
    logic [5:0]  l;
    logic        ev_end;
    logic [15:0] w;
    l      = l1a_all[mdl_ptr];
    ev_end = s || !m[7];
    if (!s) begin
      w = {2'b10, l, n};
      exp_words.push_back(w);
      mdl_wcnt = 8'd0;
      mdl_chk  = w;
    end
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        w = {2'b01, 6'd0, b, 1'b0, 3'(i)};
        exp_words.push_back(w);
        mdl_wcnt = mdl_wcnt + 8'd1;
        mdl_chk  = mdl_chk ^ w;
      end
    end
    if (ev_end) begin
      w = {2'b11, l, mdl_wcnt};
      exp_words.push_back(w);
      mdl_chk = mdl_chk ^ w;
`ifdef RDSEQ_CHKSUM_EN
      exp_words.push_back(mdl_chk);
`endif
      mdl_wcnt = 8'd0;
      mdl_chk  = 16'h0000;
      mdl_ptr++;
    end
    exp_pops.push_back(ev_end);
    e.b = b;
    e.m = m;
    e.n = n;
    e.s = s;
    blk_fifo.push_back(e);
    present();
  endtask

  task automatic monitor();
    cyc++;
    if (!mon_en) begin
      present();
      return;
    end
    if (prev_hold) begin
      hold_checks++;
      checkOutput("hold_valid", DOUT_VALID, 1);
      checkOutput("hold_dout", DOUT, prev_dout);
    end
    if (!DOUT_VALID) checkOutput("idle_dout", DOUT, 0);
    if (TRGDONE) begin
      checkOutput("pop_with_valid", DOUT_VALID, 0);
      if (exp_pops.size() == 0) checkOutput("unexpected_pop", TRGDONE, 0);
      else checkOutput("popl1an", POPL1AN, exp_pops.pop_front());
      pop_log.push_back(POPL1AN);
      if (blk_fifo.size() > 0) void'(blk_fifo.pop_front());
      if (POPL1AN) l1a_head++;
      pop_seen  = 1'b1;
      since_pop = 0;
      idle_cnt  = 0;
    end else begin
      checkOutput("popl1an_alone", POPL1AN, 0);
      if (pop_seen) begin
        since_pop++;
        if (!BUSY) idle_cnt++;
        if (DOUT_VALID) begin
          last_gap  = since_pop;
          last_idle = idle_cnt;
          pop_seen  = 1'b0;
        end
      end
    end
    if (cyc >= low_from && cyc < low_from + 3) DOUT_RDY = 1'b0;
    else if (rdy_mode == 1) DOUT_RDY = 1'b1;
    else DOUT_RDY = ($urandom_range(0, 3) != 0);
    if (DOUT_VALID && DOUT_RDY) begin
      if (exp_words.size() == 0) checkOutput("unexpected_word", DOUT_VALID, 0);
      else checkOutput("word", DOUT, exp_words.pop_front());
      acc_log.push_back(DOUT);
    end
    prev_hold = DOUT_VALID && !DOUT_RDY;
    prev_dout = DOUT;
    present();
  endtask

  task automatic tick();
    @(negedge CLK);
    monitor();
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    tick();
    while (!(blk_fifo.size() == 0 && exp_pops.size() == 0 && exp_words.size() == 0 && !BUSY)
           && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit)
      checkOutput("drain_timeout", int'(BUSY) * 1000 + exp_words.size() + exp_pops.size(), 0);
  endtask

  task automatic waitSamp(input int limit);
    int n;
    n = 0;
    while (!(DOUT_VALID && DOUT[15:14] == 2'b01) && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) checkOutput("samp_timeout", {DOUT_VALID, DOUT[15:14]}, 3'b101);
  endtask

  task automatic checkLog(input string name, input int base);
    checkOutput({name, "_len"}, acc_log.size() - base, lit.size());
    for (int i = 0; i < lit.size(); i++) begin
      if (base + i < acc_log.size()) checkOutput(name, acc_log[base + i], lit[i]);
    end
  endtask

  task automatic checkPops(input string name, input int base);
    checkOutput({name, "_pops"}, pop_log.size() - base, plit.size());
    for (int i = 0; i < plit.size(); i++) begin
      if (base + i < pop_log.size()) checkOutput({name, "_popl1an"}, pop_log[base + i], plit[i]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int base;
    int pbase;
    tests = 0; fails = 0; cyc = 0; mon_en = 1'b0; rdy_mode = 1; low_from = -10;
    prev_hold = 1'b0; prev_dout = 16'h0; hold_checks = 0; pop_seen = 1'b0;
    since_pop = 0; idle_cnt = 0; last_gap = -1; last_idle = -1;
    l1a_head = 0; mdl_ptr = 0; mdl_wcnt = 8'd0; mdl_chk = 16'h0;
    l1a_all.push_back(6'd3);
    l1a_all.push_back(6'd5);
    l1a_all.push_back(6'd9);
    l1a_all.push_back(6'd7);
    for (int i = 0; i < 400; i++) l1a_all.push_back(6'($urandom));
    RST = 1'b1;
    DOUT_RDY = 1'b0;
    present();
    repeat (3) tick();
    checkOutput("rst_dout", DOUT, 16'h0000);
    checkOutput("rst_valid", DOUT_VALID, 0);
    checkOutput("rst_trgdone", TRGDONE, 0);
    checkOutput("rst_popl1an", POPL1AN, 0);
    checkOutput("rst_busy", BUSY, 0);
    RST = 1'b0;
    mon_en = 1'b1;
    tick();

    // Single event: samples at positions 1,2,3 of block 5
    base = acc_log.size(); pbase = pop_log.size();
    applyStimulus(4'd5, 8'h0E, 8'h21, 1'b0);
    waitIdle(200);
    lit.delete();
    lit.push_back(16'h8321); lit.push_back(16'h4051); lit.push_back(16'h4052);
    lit.push_back(16'h4053); lit.push_back(16'hC303);
`ifdef RDSEQ_CHKSUM_EN
    lit.push_back(16'h0072);
`endif
    checkLog("single", base);
    plit.delete(); plit.push_back(1'b1);
    checkPops("single", pbase);

    // Two-block event: first block runs to position 7, second continues it
    base = acc_log.size(); pbase = pop_log.size();
    applyStimulus(4'd2, 8'hC0, 8'h44, 1'b0);
    applyStimulus(4'd3, 8'h03, 8'h00, 1'b1);
    waitIdle(300);
    lit.delete();
    lit.push_back(16'h8544); lit.push_back(16'h4026); lit.push_back(16'h4027);
    lit.push_back(16'h4030); lit.push_back(16'h4031); lit.push_back(16'hC504);
`ifdef RDSEQ_CHKSUM_EN
    lit.push_back(16'h4040);
`endif
    checkLog("twoblk", base);
    plit.delete(); plit.push_back(1'b0); plit.push_back(1'b1);
    checkPops("twoblk", pbase);

    // Empty mask: header followed directly by a zero-count trailer
    base = acc_log.size(); pbase = pop_log.size();
    applyStimulus(4'd1, 8'h00, 8'h00, 1'b0);
    waitIdle(200);
    lit.delete();
    lit.push_back(16'h8900); lit.push_back(16'hC900);
`ifdef RDSEQ_CHKSUM_EN
    lit.push_back(16'h4000);
`endif
    checkLog("mask0", base);
    plit.delete(); plit.push_back(1'b1);
    checkPops("mask0", pbase);

    // Backpressure: three not-ready cycles while samples are streaming
    base = acc_log.size();
    applyStimulus(4'hA, 8'h7F, 8'h5A, 1'b0);
    waitSamp(100);
    low_from = cyc + 1;
    pbase = hold_checks;
    waitIdle(300);
    checkOutput("bp_stalls", (hold_checks - pbase) >= 3, 1);
    lit.delete();
    lit.push_back(16'h875A);
    for (int i = 0; i < 7; i++) lit.push_back(16'h40A0 + 16'(i));
    lit.push_back(16'hC707);
`ifdef RDSEQ_CHKSUM_EN
    lit.push_back(16'h00FA);
`endif
    checkLog("backpressure", base);

    // Holdoff: two queued blocks, count cycles from pop to next header
    applyStimulus(4'd1, 8'h00, 8'h12, 1'b0);
    applyStimulus(4'd2, 8'h00, 8'h34, 1'b0);
    waitIdle(300);
    checkOutput("holdoff_gap", last_gap, HOLD + 3);
    checkOutput("holdoff_idle", last_idle, 1);

    // Orphan continuation: no header, count starts at zero
    base = acc_log.size();
    applyStimulus(4'd4, 8'h03, 8'h11, 1'b1);
    waitIdle(200);
    checkOutput("orphan_s0", acc_log.size() > base ? acc_log[base] : 16'hFFFF, 16'h4040);
    checkOutput("orphan_s1", acc_log.size() > base + 1 ? acc_log[base + 1] : 16'hFFFF, 16'h4041);
    if (acc_log.size() > base + 2)
      checkOutput("orphan_trl", {acc_log[base + 2][15:14], acc_log[base + 2][7:0]}, {2'b11, 8'd2});
    else
      checkOutput("orphan_len", acc_log.size() - base, 3);

    // Largest event: two full-mask blocks give a trailer count of 16
    base = acc_log.size();
    applyStimulus(4'd6, 8'hFF, 8'h01, 1'b0);
    applyStimulus(4'd7, 8'hFF, 8'h02, 1'b1);
    waitIdle(400);
    if (acc_log.size() > base + 17)
      checkOutput("wcnt16", {acc_log[base + 17][15:14], acc_log[base + 17][7:0]}, {2'b11, 8'h10});
    else
      checkOutput("wcnt16_len", acc_log.size() - base, 18);

    // Reset while samples are streaming aborts the block without any pop
    applyStimulus(4'd9, 8'h7F, 8'h77, 1'b0);
    waitSamp(100);
    mon_en = 1'b0;
    RST = 1'b1;
    tick();
    checkOutput("abort_dout", DOUT, 16'h0000);
    checkOutput("abort_valid", DOUT_VALID, 0);
    checkOutput("abort_trgdone", TRGDONE, 0);
    checkOutput("abort_popl1an", POPL1AN, 0);
    checkOutput("abort_busy", BUSY, 0);
    blk_fifo.delete();
    exp_words.delete();
    exp_pops.delete();
    mdl_wcnt = 8'd0;
    mdl_chk = 16'h0;
    mdl_ptr = l1a_head;
    present();
    tick();
    checkOutput("abort_trgdone2", TRGDONE, 0);
    RST = 1'b0;
    prev_hold = 1'b0;
    pop_seen = 1'b0;
    mon_en = 1'b1;
    tick();

    // Randomized descriptors with random ready
    rdy_mode = 0;
    for (int k = 0; k < 80; k++) begin
      logic [7:0] m;
      int r;
      while (blk_fifo.size() >= 3) tick();
      r = $urandom_range(0, 7);
      if (r == 0) m = 8'h00;
      else if (r == 1) m = 8'hFF;
      else m = 8'($urandom);
      applyStimulus(4'($urandom), m, 8'($urandom), ($urandom_range(0, 3) == 0));
      tick();
    end
    waitIdle(6000);
    checkOutput("final_words_left", exp_words.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
